// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and width limits.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_subtractor_pkg;

    // Encoding 2'd3 is unused; the FSM treats it as illegal and returns to idle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;

    // Reference arithmetic: {borrow, a - b - bin mod 2^16} for up to 16-bit operands.
    function automatic logic [16:0] sub_ref(input logic [15:0] a, input logic [15:0] b,
                                            input logic bin);
        return {1'b0, a} - {1'b0, b} - {16'd0, bin};
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done request bus between a requester and the serial subtractor.
// Latency: n/a (wires only).
// Backpressure: requester must watch busy; start while busy is dropped.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, borrow_out
    );
endinterface

// File: rtl/serial_subtractor_cell.sv
// One-bit full subtractor: d = x - y - bi, bo = borrow out.
// Latency: combinational.
// Backpressure: none.
module full_subtractor_cell (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);
    assign d  = x ^ y ^ bi;
    // Borrow when y exceeds x, or when they are equal and a borrow is already pending.
    assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock through a single cell.
// Latency: done pulses WIDTH cycles after the accept edge; one request per WIDTH+2 cycles.
// Backpressure: start is only sampled in idle; requests while busy are dropped, not queued.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic [CW-1:0]    count;
    logic             br;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;

    logic cell_d;
    logic cell_bo;

    full_subtractor_cell u_cell (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .bi (br),
        .d  (cell_d),
        .bo (cell_bo)
    );

    // Control FSM and serial datapath; all outputs are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            d_sh     <= '0;
            count    <= '0;
            br       <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        br     <= bus.bin;
                        count  <= '0;
                        d_sh   <= '0;
                        busy_q <= 1'b1;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    d_sh <= {cell_d, d_sh[WIDTH-1:1]};
                    br   <= cell_bo;
                    if (count == LAST) begin
                        // Last bit: publish the result; diff/borrow_out hold until the next completion.
                        diff_q   <= {cell_d, d_sh[WIDTH-1:1]};
                        borrow_q <= cell_bo;
                        done_q   <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed cases plus random operands against an arithmetic model.
// Latency: checks done at exactly WIDTH edges after accept, one-cycle pulse, WIDTH+2 throughput.
// Backpressure: exercises start while busy, start held high, and async reset mid-run.
module tb_serial_subtractor;

    localparam int W = 8;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cyc;
    logic [W:0] exp_q[$];

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected result from plain arithmetic: 9-bit two's complement, bit 8 is the borrow.
    function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic bi);
        int r;
        r = int'(av) - int'(bv) - int'(bi);
        return {r < 0, W'(r)};
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (exp_q.size() == 0) begin
                chk("done_without_accept", 1, 0);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                chk("diff", int'(bus.diff), int'(e[W-1:0]));
                chk("borrow_out", int'(bus.borrow_out), int'(e[W]));
            end
        end
    end

    // Called aligned at #1 after a rising edge; returns aligned the same way with busy low.
    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        int lat;
        wait_idle();
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        bus.bin   = bi;
        exp_q.push_back(model(av, bv, bi));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.bin   = 1'($urandom);
        chk("busy_after_accept", int'(bus.busy), 1);
        lat = 0;
        while (!bus.done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, W);
        chk("busy_during_done", int'(bus.busy), 1);
        @(posedge clk);
        #1;
        chk("done_one_cycle", int'(bus.done), 0);
        chk("busy_released", int'(bus.busy), 0);
    endtask

    initial begin
        int prev;
        total     = 0;
        bad       = 0;
        cyc       = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;

        #2;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_diff", int'(bus.diff), 0);
        chk("rst_borrow", int'(bus.borrow_out), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Directed arithmetic cases.
        do_op(8'd100, 8'd58, 1'b0);
        do_op(8'd5, 8'd7, 1'b0);
        do_op(8'd0, 8'd0, 1'b1);
        do_op(8'd255, 8'd255, 1'b0);
        do_op(8'h80, 8'h01, 1'b0);
        chk("diff_7f_direct", int'(bus.diff), 8'h7F);

        // A start pulse while busy is dropped.
        wait_idle();
        bus.start = 1'b1; bus.a = 8'd9; bus.b = 8'd3; bus.bin = 1'b0;
        exp_q.push_back(model(8'd9, 8'd3, 1'b0));
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.a = 8'd1; bus.b = 8'd2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("busy_ignoring_start", int'(bus.busy), 1);
        wait_idle();
        repeat (4) @(posedge clk);
        #1;
        chk("ignored_result", int'(bus.diff), 6);

        // Result holds through the next accept.
        bus.start = 1'b1; bus.a = 8'd1; bus.b = 8'd200; bus.bin = 1'b0;
        exp_q.push_back(model(8'd1, 8'd200, 1'b0));
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("hold_on_accept", int'(bus.diff), 6);
        wait_idle();

        // Start held high re-triggers every WIDTH+2 cycles.
        bus.start = 1'b1; bus.a = 8'd200; bus.b = 8'd77; bus.bin = 1'b1;
        prev = 0;
        for (int n = 0; n < 4; n++) begin
            wait_idle();
            exp_q.push_back(model(8'd200, 8'd77, 1'b1));
            @(posedge clk); #1;
            chk("held_accept_busy", int'(bus.busy), 1);
            if (n > 0) chk("held_period", cyc - prev, W + 2);
            prev = cyc;
        end
        bus.start = 1'b0;
        wait_idle();

        // Asynchronous reset in the middle of a run discards it.
        bus.start = 1'b1; bus.a = 8'd50; bus.b = 8'd20; bus.bin = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_done", int'(bus.done), 0);
        chk("midrst_diff", int'(bus.diff), 0);
        chk("midrst_borrow", int'(bus.borrow_out), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("no_done_after_rst", int'(bus.diff), 0);
        do_op(8'd20, 8'd13, 1'b0);

        // Random operands.
        for (int i = 0; i < 1000; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
